cache_backing_mem: RTL and testbench



---
 rtl/cache_pkg.sv | 19 +
 rtl/cache_backing_mem_if.sv | 23 ++
 rtl/wb_fifo.sv | 56 +++++
 rtl/cache_backing_mem.sv | 120 ++++++++++++
 tb/tb_cache_backing_mem.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// cache_pkg: shared types and constants for the cache backing memory
package cache_pkg;
    localparam int ADDR_W  = 5;
    localparam int DATA_W  = 3;
    localparam int INDEX_W = 2;
    localparam int TAG_W   = 3;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    typedef enum logic [2:0] {IDLE, WB_WR, RF_FWD, RF_RD, RF_RSP} state_e;

    // Power-on contents mirror the tag-as-data fill the cache uses on a miss.
    function automatic logic [DATA_W-1:0] init_word(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1 -: TAG_W];
    endfunction
endpackage

// File: rtl/cache_backing_mem_if.sv
// cache_backing_mem_if: write-back and refill channels between cache and backing memory
interface cache_backing_mem_if;
    import cache_pkg::*;
    logic              wb_valid;
    logic              wb_ready;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              rf_req;
    logic              rf_ready;
    logic [ADDR_W-1:0] rf_addr;
    logic              rf_valid;
    logic [DATA_W-1:0] rf_data;
    logic              busy;

    modport master (
        output wb_valid, wb_addr, wb_data, rf_req, rf_addr,
        input  wb_ready, rf_ready, rf_valid, rf_data, busy
    );
    modport slave (
        input  wb_valid, wb_addr, wb_data, rf_req, rf_addr,
        output wb_ready, rf_ready, rf_valid, rf_data, busy
    );
endinterface

// File: rtl/wb_fifo.sv
// wb_fifo: write-back queue with a youngest-entry address match for refill forwarding
module wb_fifo import cache_pkg::*; #(
    parameter int DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              push_i,
    input  wb_entry_t         push_entry_i,
    input  logic              pop_i,
    input  logic [ADDR_W-1:0] match_addr_i,
    output wb_entry_t         head_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              hit_o,
    output logic [DATA_W-1:0] hit_data_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    wb_entry_t       mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = count_q == CW'(DEPTH);
    assign empty_o = count_q == '0;

    always_ff @(posedge clock) begin
        if (push_i) mem_q[wr_ptr_q] <= push_entry_i;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop_i) rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    // Scan oldest to youngest so the last valid match left standing is the youngest.
    always_comb begin
        hit_o      = 1'b0;
        hit_data_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count_q && mem_q[rd_ptr_q + PW'(i)].addr == match_addr_i) begin
                hit_o      = 1'b1;
                hit_data_o = mem_q[rd_ptr_q + PW'(i)].data;
            end
        end
    end
endmodule

// File: rtl/cache_backing_mem.sv
// cache_backing_mem: main-memory back end draining cache write-backs and serving refills
module cache_backing_mem import cache_pkg::*; #(
    parameter int WB_DEPTH = 4,
    parameter int MEM_LAT  = 2
) (
    input  logic               clock,
    input  logic               reset_n,
    cache_backing_mem_if.slave bus
);
    localparam int LW = $clog2(MEM_LAT + 1);

    state_e            state_q, state_d;
    logic [LW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] fwd_q, fwd_d;
    logic [DATA_W-1:0] rf_data_q, rf_data_d;
    logic              rf_pend_q;
    logic [ADDR_W-1:0] rf_addr_q;
    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    logic              push, pop, capture, full, empty, hit;
    logic [DATA_W-1:0] hit_data;
    wb_entry_t         wb_in, head;

    assign wb_in   = '{addr: bus.wb_addr, data: bus.wb_data};
    assign push    = bus.wb_valid && !full;
    assign capture = bus.rf_req && !rf_pend_q;
    assign pop     = state_q == WB_WR && cnt_q == '0;

    assign bus.wb_ready = !full;
    assign bus.rf_ready = !rf_pend_q;
    assign bus.rf_valid = state_q == RF_RSP;
    assign bus.rf_data  = rf_data_q;
    assign bus.busy     = state_q != IDLE || !empty;

    wb_fifo #(.DEPTH(WB_DEPTH)) u_wb_fifo (
        .clock        (clock),
        .reset_n      (reset_n),
        .push_i       (push),
        .push_entry_i (wb_in),
        .pop_i        (pop),
        .match_addr_i (rf_addr_q),
        .head_o       (head),
        .full_o       (full),
        .empty_o      (empty),
        .hit_o        (hit),
        .hit_data_o   (hit_data)
    );

    // Counter spans MEM_LAT+1 cycles per access: the array cycles plus one to settle the address.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        fwd_d     = fwd_q;
        rf_data_d = rf_data_q;
        case (state_q)
            IDLE: begin
                if (rf_pend_q && hit) begin
                    state_d = RF_FWD;
                    fwd_d   = hit_data;
                end else if (rf_pend_q) begin
                    state_d = RF_RD;
                    cnt_d   = LW'(MEM_LAT);
                end else if (!empty) begin
                    state_d = WB_WR;
                    cnt_d   = LW'(MEM_LAT);
                end
            end
            WB_WR: begin
                cnt_d   = cnt_q - LW'(1);
                state_d = cnt_q == '0 ? IDLE : WB_WR;
            end
            RF_RD: begin
                cnt_d = cnt_q - LW'(1);
                if (cnt_q == '0) begin
                    state_d   = RF_RSP;
                    rf_data_d = mem_q[rf_addr_q];
                end
            end
            RF_FWD: begin
                state_d   = RF_RSP;
                rf_data_d = fwd_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            fwd_q     <= '0;
            rf_data_q <= '0;
            rf_pend_q <= 1'b0;
            rf_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            fwd_q     <= fwd_d;
            rf_data_q <= rf_data_d;
            if (capture) begin
                rf_pend_q <= 1'b1;
                rf_addr_q <= bus.rf_addr;
            end else if (state_q == RF_RSP) begin
                rf_pend_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int a = 0; a < 2**ADDR_W; a++) mem_q[a] <= init_word(ADDR_W'(a));
        end else if (pop) begin
            mem_q[head.addr] <= head.data;
        end
    end

    a_rf_protocol: assert property (@(posedge clock) disable iff (!reset_n)
        !(bus.rf_req && !bus.rf_ready))
        else $warning("rf_req while a refill is outstanding; request ignored");
endmodule

// File: tb/tb_cache_backing_mem.sv
// tb_cache_backing_mem: directed and random checks against a latest-write-wins memory model
module tb_cache_backing_mem;
    logic clock;
    logic reset_n;

    cache_backing_mem_if ifc();

    cache_backing_mem #(.WB_DEPTH(4), .MEM_LAT(2)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (ifc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // A refill must return the newest data ever written to its address, else the init fill.
    logic [2:0] mdl [32];
    logic [2:0] exp_q [$];
    logic [2:0] last_rsp;
    int n_chk, n_fail, cyc, cap_cyc, exp_lat, last_lat;
    bit pushed, captured, rsp_seen;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int a = 0; a < 32; a++) mdl[a] = 3'(a >> 2);
        exp_q.delete();
        last_rsp = 3'd0;
    endtask

    task automatic tick();
        bit p, c;
        p = ifc.wb_valid && ifc.wb_ready;
        c = ifc.rf_req && ifc.rf_ready;
        @(posedge clock);
        cyc++;
        if (p) mdl[ifc.wb_addr] = ifc.wb_data;
        if (c) begin
            exp_q.push_back(mdl[ifc.rf_addr]);
            cap_cyc = cyc;
        end
        pushed   = p;
        captured = c;
        #1;
        if (ifc.rf_valid && exp_q.size() > 0) begin
            check("rf_data", 32'(ifc.rf_data), 32'(exp_q.pop_front()));
            last_lat = cyc - cap_cyc;
            if (exp_lat >= 0) check("rf_latency", last_lat, exp_lat);
            last_rsp = ifc.rf_data;
            rsp_seen = 1'b1;
        end else begin
            check("rf_valid_unexpected", 32'(ifc.rf_valid), 0);
            check("rf_data_hold", 32'(ifc.rf_data), 32'(last_rsp));
        end
    endtask

    task automatic wait_rsp();
        for (int i = 0; i < 40 && !rsp_seen; i++) tick();
        check("rsp_seen", 32'(rsp_seen), 1);
    endtask

    task automatic wait_rf_ready();
        for (int i = 0; i < 40 && !ifc.rf_ready; i++) tick();
        check("rf_ready", 32'(ifc.rf_ready), 1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 80 && ifc.busy; i++) tick();
        check("idle", 32'(ifc.busy), 0);
    endtask

    task automatic refill(input logic [4:0] a, input int lat);
        wait_rf_ready();
        ifc.rf_req  = 1'b1;
        ifc.rf_addr = a;
        exp_lat     = lat;
        rsp_seen    = 1'b0;
        tick();
        ifc.rf_req = 1'b0;
        wait_rsp();
    endtask

    task automatic push(input logic [4:0] a, input logic [2:0] d, output int waited);
        ifc.wb_valid = 1'b1;
        ifc.wb_addr  = a;
        ifc.wb_data  = d;
        waited       = 0;
        do begin
            tick();
            waited++;
        end while (!pushed && waited < 40);
        ifc.wb_valid = 1'b0;
        check("push_accept", 32'(pushed), 1);
    endtask

    task automatic push_refill(input logic [4:0] a, input logic [2:0] d, input int lat);
        wait_rf_ready();
        ifc.wb_valid = 1'b1;
        ifc.wb_addr  = a;
        ifc.wb_data  = d;
        ifc.rf_req   = 1'b1;
        ifc.rf_addr  = a;
        exp_lat      = lat;
        rsp_seen     = 1'b0;
        tick();
        ifc.wb_valid = 1'b0;
        ifc.rf_req   = 1'b0;
        check("pr_push", 32'(pushed), 1);
        check("pr_capture", 32'(captured), 1);
        wait_rsp();
    endtask

    function automatic logic [4:0] rnd_addr();
        return ($urandom_range(0, 1) == 1) ? 5'($urandom_range(8, 11)) : 5'($urandom);
    endfunction

    initial begin
        int w;
        n_chk = 0; n_fail = 0; cyc = 0; cap_cyc = 0; exp_lat = -1; last_lat = 0;
        ifc.wb_valid = 1'b0; ifc.wb_addr = '0; ifc.wb_data = '0;
        ifc.rf_req = 1'b0; ifc.rf_addr = '0;
        model_reset();
        reset_n = 1'b0;
        #23 reset_n = 1'b1;
        check("rst_wb_ready", 32'(ifc.wb_ready), 1);
        check("rst_rf_ready", 32'(ifc.rf_ready), 1);
        check("rst_rf_valid", 32'(ifc.rf_valid), 0);
        check("rst_rf_data", 32'(ifc.rf_data), 0);
        check("rst_busy", 32'(ifc.busy), 0);

        // Cold read of the init pattern.
        refill(5'b10110, 4);
        check("t1_data", 32'(last_rsp), 5);
        wait_idle();

        // Forward from the FIFO, then the same address after it has drained.
        push_refill(5'b01001, 3'b111, 2);
        check("t2_fwd", 32'(last_rsp), 7);
        wait_idle();
        refill(5'b01001, 4);
        check("t2_arr", 32'(last_rsp), 7);

        // Two writes to one address: the younger must win.
        wait_idle();
        push(5'b00011, 3'b001, w);
        push_refill(5'b00011, 3'b110, -1);
        check("t3_youngest", 32'(last_rsp), 6);

        // Fill the FIFO, back-pressure the fifth offer, read everything back.
        wait_idle();
        for (int i = 0; i < 4; i++) push(5'(16 + i), 3'(i) ^ 3'b101, w);
        check("t4_full", 32'(ifc.wb_ready), 0);
        push(5'd20, 3'b010, w);
        check("t4_held", 32'(w >= 2), 1);
        wait_idle();
        for (int i = 0; i < 5; i++) refill(5'(16 + i), 4);

        // Refill behind an in-flight write, plus an illegal second request.
        wait_idle();
        push(5'b00101, 3'b010, w);
        tick();
        ifc.rf_req  = 1'b1;
        ifc.rf_addr = 5'b11000;
        exp_lat     = -1;
        rsp_seen    = 1'b0;
        tick();
        check("t5_capture", 32'(captured), 1);
        ifc.rf_addr = 5'b00001;
        tick();
        check("t5_ignored", 32'(captured), 0);
        ifc.rf_req = 1'b0;
        wait_rsp();
        check("t5_data", 32'(last_rsp), 6);
        check("t5_waited", 32'(last_lat > 4), 1);
        repeat (6) tick();
        refill(5'b00101, 4);
        check("t5_written", 32'(last_rsp), 2);

        // Reset in the middle of an array read with two write-backs pending.
        wait_idle();
        ifc.wb_valid = 1'b1; ifc.wb_addr = 5'b01110; ifc.wb_data = 3'b000;
        ifc.rf_req = 1'b1; ifc.rf_addr = 5'b11111; exp_lat = -1;
        tick();
        ifc.rf_req = 1'b0;
        ifc.wb_addr = 5'b01111;
        tick();
        ifc.wb_valid = 1'b0;
        tick();
        reset_n = 1'b0;
        #2;
        check("t6_rf_valid", 32'(ifc.rf_valid), 0);
        check("t6_busy", 32'(ifc.busy), 0);
        check("t6_wb_ready", 32'(ifc.wb_ready), 1);
        check("t6_rf_ready", 32'(ifc.rf_ready), 1);
        reset_n = 1'b1;
        model_reset();
        repeat (8) tick();
        refill(5'b01110, 4);
        check("t6_init_a", 32'(last_rsp), 3);
        refill(5'b01111, 4);
        check("t6_init_b", 32'(last_rsp), 3);
        refill(5'b11111, 4);
        check("t6_init_c", 32'(last_rsp), 7);

        // Random mix; pushes are withheld while a refill waits so the model's order is exact.
        exp_lat = -1;
        for (int i = 0; i < 400; i++) begin
            ifc.wb_valid = ifc.rf_ready && ($urandom_range(0, 2) == 0);
            ifc.wb_addr  = rnd_addr();
            ifc.wb_data  = 3'($urandom);
            ifc.rf_req   = ifc.rf_ready && ($urandom_range(0, 3) == 0);
            ifc.rf_addr  = rnd_addr();
            tick();
        end
        ifc.wb_valid = 1'b0;
        ifc.rf_req   = 1'b0;
        for (int i = 0; i < 60 && exp_q.size() > 0; i++) tick();
        check("rnd_drain", exp_q.size(), 0);
        wait_idle();
        for (int a = 0; a < 32; a++) refill(5'(a), 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
